optest_shift_check: RTL and testbench

Self-checking result stage that sits directly downstream of the registered shift-operator test block. It observes the same operand/mode bus that feeds that block, computes a golden 8-bit result with matching one-cycle latency, compares it against the block's `y`, and accumulates an error count and a 16-bit signature over a run of NVEC vectors. It reports pass/fail once the run completes.

---
 rtl/optest_shift_check.sv | 124 ++++++++++++
 tb/tb_optest_shift_check.sv | 139 +++++++++++++
 2 files changed

// File: rtl/optest_shift_check.sv
// Golden-model checker for the registered shift-operator test block: compares y against a
// one-cycle-delayed expected value over NVEC vectors. Define OPTEST_FULL_MODES_EN to model all 16 modes.
module optest_shift_check #(
    parameter int unsigned NVEC = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  mode,
    input  logic [3:0]  u1,
    input  logic [3:0]  u2,
    input  logic [3:0]  s1,
    input  logic [3:0]  s2,
    input  logic [7:0]  y,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [7:0]  err_count,
    output logic [7:0]  first_err_idx,
    output logic [15:0] signature
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    localparam logic [8:0] LAST_IDX = 9'(NVEC - 1);

    state_t      state_q, state_d;
    logic [8:0]  cnt_q, cnt_d;
    logic [7:0]  exp_q, exp_d;
    logic        exp_v_q, exp_v_d;
    logic [7:0]  err_q, err_d;
    logic [7:0]  first_q, first_d;
    logic [15:0] sig_q, sig_d;

    logic [7:0]  lhs;
    logic [3:0]  amt;
    logic [7:0]  gold;
`ifdef OPTEST_FULL_MODES_EN
    logic signed [7:0] sra;
`endif

    // mode[1] picks the signed left operand, mode[0] the s2 shift amount; modes 0 and 3 fit this too
    always_comb begin
        lhs = mode[1] ? {{4{s1[3]}}, s1} : {4'h0, u1};
        amt = mode[0] ? s2 : u2;
`ifdef OPTEST_FULL_MODES_EN
        sra = $signed(lhs) >>> amt;
        case (mode[3:2])
            2'b01:   gold = lhs >> amt;
            2'b11:   gold = mode[1] ? sra : (lhs >> amt);
            default: gold = lhs << amt;
        endcase
`else
        gold = (mode == 4'd0 || mode == 4'd3) ? (lhs << amt) : 8'h42;
`endif
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        exp_d   = exp_q;
        exp_v_d = 1'b0;
        err_d   = err_q;
        first_d = first_q;
        sig_d   = sig_q;

        if (exp_v_q) begin
            sig_d = {sig_q[14:0], sig_q[15] ^ sig_q[14] ^ sig_q[12] ^ sig_q[3]} ^ {8'h00, y};
            if (y != exp_q) begin
                if (err_q != 8'hFF) err_d = err_q + 8'd1;
                // counter already advanced past the vector now being compared
                if (first_q == 8'hFF) first_d = 8'(cnt_q - 9'd1);
            end
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                    err_d   = '0;
                    first_d = '1;
                    sig_d   = '1;
                end
            end
            S_RUN: begin
                exp_d   = gold;
                exp_v_d = 1'b1;
                cnt_d   = cnt_q + 9'd1;
                if (cnt_q == LAST_IDX) state_d = S_DRAIN;
            end
            S_DRAIN: state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            exp_q   <= '0;
            exp_v_q <= 1'b0;
            err_q   <= '0;
            first_q <= '1;
            sig_q   <= '1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            exp_q   <= exp_d;
            exp_v_q <= exp_v_d;
            err_q   <= err_d;
            first_q <= first_d;
            sig_q   <= sig_d;
        end
    end

    assign busy          = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done          = (state_q == S_DONE);
    assign pass          = done && (err_q == 8'd0);
    assign err_count     = err_q;
    assign first_err_idx = first_q;
    assign signature     = sig_q;

endmodule

// File: tb/tb_optest_shift_check.sv
// Directed bench for optest_shift_check with NVEC=4; expected values are hand-computed constants.
module tb_optest_shift_check;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  mode = '0, u1 = '0, u2 = '0, s1 = '0, s2 = '0;
    logic [7:0]  y = '0;
    logic        busy, done, pass;
    logic [7:0]  err_count, first_err_idx;
    logic [15:0] signature;

    int unsigned tests = 0;
    int unsigned fails = 0;

    logic [3:0] vm[4], vu1[4], vu2[4], vs1[4], vs2[4];
    logic [7:0] vy[4];

    optest_shift_check #(.NVEC(4)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .u1(u1), .u2(u2), .s1(s1), .s2(s2), .y(y),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .first_err_idx(first_err_idx), .signature(signature)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_vec(input int i, input logic [3:0] m, input logic [3:0] a, input logic [3:0] b,
                           input logic [3:0] c, input logic [3:0] d, input logic [7:0] yy);
        vm[i] = m; vu1[i] = a; vu2[i] = b; vs1[i] = c; vs2[i] = d; vy[i] = yy;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_busy"}, 16'(busy), 16'h0);
        chk({tag, "_done"}, 16'(done), 16'h0);
        chk({tag, "_pass"}, 16'(pass), 16'h0);
        chk({tag, "_err"}, 16'(err_count), 16'h0);
        chk({tag, "_first"}, 16'(first_err_idx), 16'h00FF);
        chk({tag, "_sig"}, signature, 16'hFFFF);
    endtask

    // One full run: y for vector i is presented in the cycle after its operands.
    task automatic run(input bit poke_start);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mode = vm[i]; u1 = vu1[i]; u2 = vu2[i]; s1 = vs1[i]; s2 = vs2[i];
            y = (i == 0) ? 8'h00 : vy[i-1];
            if (poke_start && i == 1) start = 1'b1;
            tick();
            start = 1'b0;
        end
        chk("drain_busy", 16'(busy), 16'h1);
        chk("drain_done", 16'(done), 16'h0);
        y = vy[3];
        tick();
        chk("run_done", 16'(done), 16'h1);
        chk("run_busy", 16'(busy), 16'h0);
    endtask

    initial begin
        tick();
        tick();
        check_reset_values("reset");
        rst = 1'b0;
        tick();

        set_vec(0, 4'd0, 4'd3, 4'd2, 4'h0, 4'h0, 8'h0C);
        set_vec(1, 4'd3, 4'h0, 4'h0, 4'hF, 4'd3, 8'hF8);
        set_vec(2, 4'd3, 4'h0, 4'h0, 4'hF, 4'hF, 8'h00);
`ifdef OPTEST_FULL_MODES_EN
        set_vec(3, 4'd14, 4'h0, 4'd1, 4'h8, 4'h0, 8'hFC);
`else
        set_vec(3, 4'd5, 4'h9, 4'd1, 4'h7, 4'h2, 8'h42);
`endif
        run(1'b0);
        chk("good_err", 16'(err_count), 16'h0);
        chk("good_first", 16'(first_err_idx), 16'h00FF);
        chk("good_pass", 16'(pass), 16'h1);

        vy[2] = 8'h55;
        run(1'b0);
        chk("bad_err", 16'(err_count), 16'h1);
        chk("bad_first", 16'(first_err_idx), 16'h0002);
        chk("bad_pass", 16'(pass), 16'h0);
        tick();
        chk("bad_hold_err", 16'(err_count), 16'h1);
        chk("bad_hold_done", 16'(done), 16'h1);

        for (int i = 0; i < 4; i++) set_vec(i, 4'd0, 4'h0, 4'h0, 4'h0, 4'h0, 8'h00);
        run(1'b0);
        chk("zero_sig", signature, 16'hFFF0);
        chk("zero_err", 16'(err_count), 16'h0);
        chk("zero_pass", 16'(pass), 16'h1);
        run(1'b1);
        chk("rerun_sig", signature, 16'hFFF0);
        chk("rerun_pass", 16'(pass), 16'h1);

        vy[0] = 8'h11;
        start = 1'b1;
        tick();
        start = 1'b0;
        mode = 4'd0; u1 = 4'h0; u2 = 4'h0; y = 8'h00;
        tick();
        y = vy[0];
        tick();
        chk("abort_err_before", 16'(err_count), 16'h1);
        chk("abort_busy_before", 16'(busy), 16'h1);
        rst = 1'b1;
        #1;
        check_reset_values("abort");
        tick();
        rst = 1'b0;
        vy[0] = 8'h00;
        tick();
        run(1'b0);
        chk("post_abort_sig", signature, 16'hFFF0);
        chk("post_abort_err", 16'(err_count), 16'h0);
        chk("post_abort_pass", 16'(pass), 16'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
